// File: rtl/modsq_carry_normalizer_if.sv
// -----------------------------------------------------------------------------
// modsq_carry_normalizer_if
// Purpose : bundles the squarer-side input handshake and the downstream result
//           handshake of the carry normalizer.
// Signals :
//   sq_valid  - producer -> normalizer, one-cycle pulse, sq_in is valid
//   sq_in     - producer -> normalizer, one 2*WORD_LEN-bit field per coefficient
//   in_ready  - normalizer -> producer, sq_in is captured if sq_valid is high
//   out_data  - normalizer -> consumer, normalized nonredundant integer
//   out_valid - normalizer -> consumer, out_data/overflow are valid
//   out_ready - consumer -> normalizer, result accepted
//   overflow  - normalizer -> consumer, carry out of the top coefficient
//   overrun   - normalizer -> producer, sticky dropped-input flag
// Modports: master = producer/consumer side, slave = normalizer side.
// -----------------------------------------------------------------------------
interface modsq_carry_normalizer_if #(
  parameter int NUM_ELEMENTS = 66,
  parameter int WORD_LEN     = 16
);
  logic                                sq_valid;
  logic [NUM_ELEMENTS*WORD_LEN*2-1:0]  sq_in;
  logic                                in_ready;
  logic [NUM_ELEMENTS*WORD_LEN-1:0]    out_data;
  logic                                out_valid;
  logic                                out_ready;
  logic                                overflow;
  logic                                overrun;

  modport master (
    output sq_valid, sq_in, out_ready,
    input  in_ready, out_data, out_valid, overflow, overrun
  );

  modport slave (
    input  sq_valid, sq_in, out_ready,
    output in_ready, out_data, out_valid, overflow, overrun
  );
endinterface

// File: rtl/modsq_carry_normalizer.sv
// -----------------------------------------------------------------------------
// modsq_carry_normalizer
// Purpose : takes the redundant coefficient vector produced by a modular
//           squarer (each coefficient up to COEF_BITS wide) and ripples the
//           carries through it, one coefficient per clock, producing a
//           nonredundant NUM_ELEMENTS*WORD_LEN-bit integer.
// Ports   :
//   clk   - single clock
//   reset - asynchronous active-high reset
//   bus   - modsq_carry_normalizer_if.slave (see interface header)
// Timing  : a capture on edge E0 yields out_valid after edge E0+NUM_ELEMENTS,
//           i.e. the result is valid in the (NUM_ELEMENTS+1)-th cycle after
//           the cycle in which sq_valid was presented.
// -----------------------------------------------------------------------------
module modsq_carry_normalizer #(
  parameter int MOD_LEN            = 1024,
  parameter int WORD_LEN           = 16,
  parameter int REDUNDANT_ELEMENTS = 2,
  parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
  parameter int COEF_BITS          = 17,
  parameter int SQ_IN_BITS         = NUM_ELEMENTS * WORD_LEN * 2
) (
  input  logic                         clk,
  input  logic                         reset,
  modsq_carry_normalizer_if.slave      bus
);

  localparam int FIELD_W = SQ_IN_BITS / NUM_ELEMENTS;
  localparam int IDX_W   = $clog2(NUM_ELEMENTS);
  localparam int SUM_W   = COEF_BITS + 1;
  localparam int OUT_W   = NUM_ELEMENTS * WORD_LEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [COEF_BITS-1:0]   coef_q [NUM_ELEMENTS];
  logic [COEF_BITS-1:0]   coef_d [NUM_ELEMENTS];
  // Largest carry is 2: (2^17-1 + 2) >> 16 == 2.
  logic [1:0]             carry_q, carry_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   overrun_q, overrun_d;

  logic                   in_ready_s;
  logic                   load_s;
  logic [SUM_W-1:0]       sum_s;

  // Ready is combinational so a HOLD cycle with out_ready can take a new input.
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.overrun   = overrun_q;

  // Next-state, carry-ripple datapath and input capture.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    overrun_d   = overrun_q | (bus.sq_valid & ~in_ready_s);
    load_s      = 1'b0;
    sum_s       = SUM_W'(coef_q[idx_q]) + SUM_W'(carry_q);
    for (int j = 0; j < NUM_ELEMENTS; j++) begin
      coef_d[j] = coef_q[j];
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.sq_valid) begin
          load_s  = 1'b1;
          state_d = ST_PROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROP: begin
        // Words not reached yet keep their previous value.
        out_data_d[idx_q*WORD_LEN +: WORD_LEN] = sum_s[WORD_LEN-1:0];
        carry_d = sum_s[WORD_LEN +: 2];
        if (idx_q == IDX_W'(NUM_ELEMENTS - 1)) begin
          overflow_d  = |sum_s[SUM_W-1:WORD_LEN];
          out_valid_d = 1'b1;
          idx_d       = {IDX_W{1'b0}};
          state_d     = ST_HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (bus.sq_valid) begin
            load_s  = 1'b1;
            state_d = ST_PROP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Capture keeps only the low COEF_BITS of each field.
    if (load_s) begin
      carry_d = 2'd0;
      idx_d   = {IDX_W{1'b0}};
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        coef_d[j] = bus.sq_in[j*FIELD_W +: COEF_BITS];
      end
    end else begin
      carry_d = carry_d;
    end
  end

  // State, result and coefficient registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      carry_q     <= 2'd0;
      idx_q       <= {IDX_W{1'b0}};
      out_data_q  <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        coef_q[j] <= {COEF_BITS{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      overrun_q   <= overrun_d;
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
        coef_q[j] <= coef_d[j];
      end
    end
  end

endmodule

// File: doc/modsq_carry_normalizer.md
MODSQ_CARRY_NORMALIZER -- requirements
Module: modsq_carry_normalizer

Interface
REQ-001 SHALL have parameter MOD_LEN, default 1024, modulus bit length.
REQ-002 SHALL have parameter WORD_LEN, default 16, nonredundant bits per coefficient.
REQ-003 SHALL have parameter REDUNDANT_ELEMENTS, default 2, number of extra upper coefficients.
REQ-004 SHALL have parameter NUM_ELEMENTS, default MOD_LEN/WORD_LEN + REDUNDANT_ELEMENTS (66), number of coefficients.
REQ-005 SHALL have parameter COEF_BITS, default 17, significant bits per incoming coefficient.
REQ-006 SHALL have parameter SQ_IN_BITS, default NUM_ELEMENTS*WORD_LEN*2, packed input width, one 32-bit field per coefficient.
REQ-007 Ports (name, direction, width, meaning): clk, in, 1, single clock for all logic; reset, in, 1, asynchronous active-high reset.
REQ-008 sq_valid, in, 1: one-cycle pulse; sq_in holds a valid squarer result.
REQ-009 sq_in, in, SQ_IN_BITS: coefficient j in bits [j*2*WORD_LEN +: 2*WORD_LEN], lowest index least significant.
REQ-010 in_ready, out, 1: block will capture sq_in if sq_valid is high this cycle.
REQ-011 out_data, out, NUM_ELEMENTS*WORD_LEN: normalized nonredundant integer.
REQ-012 out_valid, out, 1: out_data and overflow are valid.
REQ-013 out_ready, in, 1: downstream accepts out_data.
REQ-014 overflow, out, 1: final carry out of the top coefficient was nonzero.
REQ-015 overrun, out, 1: sticky; a sq_valid arrived while in_ready was low.

Function
REQ-016 SHALL implement states IDLE, PROP, HOLD.
REQ-017 in_ready SHALL equal (state==IDLE) or (state==HOLD and out_ready).
REQ-018 On sq_valid and in_ready: latch coefficient j as sq_in[j*2*WORD_LEN +: COEF_BITS] into a register array, ignore field bits above COEF_BITS, clear carry, set index to 0, go to PROP.
REQ-019 Each PROP cycle, for index i: sum = coef[i] + carry; out_data word i = sum[WORD_LEN-1:0]; carry = sum >> WORD_LEN; increment i.
REQ-020 The carry register SHALL be 2 bits wide; the maximum carry is 2.
REQ-021 After i = NUM_ELEMENTS-1 is processed: overflow = (final carry != 0), out_valid = 1, go to HOLD.
REQ-022 Latency: out_valid SHALL rise exactly NUM_ELEMENTS+1 cycles (67 at defaults) after the cycle sq_valid is sampled.
REQ-023 In HOLD, out_data, overflow and out_valid SHALL stay stable until out_ready is high.
REQ-024 In HOLD with out_ready high: out_valid drops the next cycle.
REQ-025 In HOLD with out_ready high and no sq_valid: go to IDLE.
REQ-026 In HOLD with out_ready and sq_valid both high: capture the new input and go directly to PROP, giving back-to-back operation without a bubble.
REQ-027 sq_valid with in_ready low SHALL be dropped and SHALL set overrun; the operation in progress is unaffected.
REQ-028 out_data words not yet processed in the current pass SHALL hold their previous values; only out_valid qualifies out_data.

Reset
REQ-029 Asserting reset at any time, including mid-PROP, SHALL asynchronously force: state=IDLE, out_valid=0, overflow=0, overrun=0, out_data=0, carry=0, index=0.
REQ-030 While reset is asserted, in_ready SHALL be 1 and the captured coefficient array is don't-care.
REQ-031 The first sq_valid after reset deassertion SHALL be processed normally.

Verification
REQ-032 Coef0=0x1FFFF, all others 0, out_ready=1 -> 67 cycles later out_valid=1; word0=0xFFFF, word1=0x0001, remaining words 0; overflow=0.
REQ-033 Coef0=0x10000, coef1..65=0x0FFFF -> all 66 words=0x0000, overflow=1.
REQ-034 Every 32-bit field=0xFFFE0005 -> the upper 15 bits are ignored; every word=0x0005, overflow=0.
REQ-035 out_ready held low for 10 cycles after out_valid, with a second sq_valid in that window -> out_data stable for all 10 cycles, second input dropped, overrun=1 and sticky until reset.
REQ-036 Reset pulsed at PROP index 30 -> all outputs 0, state IDLE; a new sq_valid 3 cycles later yields the correct result 67 cycles after capture.
REQ-037 out_ready and a new sq_valid in the same HOLD cycle -> out_valid low for exactly 66 cycles, second result valid 67 cycles after that edge, overrun=0.
